// File: rtl/ad79x8_slave.sv
// AD79x8-style serial ADC slave: 16-bit frames, MSB-first result out, control word in.
// Define AD79X8_SEQUENCER_EN to enable round-robin channel advance after WRITE=0 frames.
module ad79x8_slave #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_BITS   = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cs,
  input  logic                   sclk,
  input  logic                   d_in,
  input  logic [8*DATA_BITS-1:0] samples,
  output logic                   d_out,
  output logic                   d_out_oe,
  output logic [2:0]             cur_chan,
  output logic                   cfg_write,
  output logic                   frame_abort
);
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  localparam logic [1:0] FLUSH = 2'(SYNC_STAGES);

  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;
  logic                   cs_prev_q, cs_prev_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic [1:0]             flush_cnt_q, flush_cnt_d;
  logic                   armed_q, armed_d;
  state_t                 state_q, state_d;
  logic [15:0]            out_sr_q, out_sr_d;
  logic [15:0]            ctl_sr_q, ctl_sr_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic                   d_out_q, d_out_d;
  logic                   d_out_oe_q, d_out_oe_d;
  logic [2:0]             cur_chan_q, cur_chan_d;
  logic                   cfg_write_q, cfg_write_d;
  logic                   frame_abort_q, frame_abort_d;
`ifdef AD79X8_SEQUENCER_EN
  logic                   seq_q, seq_d;
`endif

  logic        cs_s, sclk_s, din_s;
  logic        cs_fall, cs_rise, sclk_fall;
  logic [15:0] ctl_new;
  logic [11:0] chan_res [8];
  logic        ctl_unused;

  // Results are left-justified into 12 bits with zero-filled LSBs.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_chan
      assign chan_res[gi] = 12'(samples[gi*DATA_BITS +: DATA_BITS]) << (12 - DATA_BITS);
    end
  endgenerate

  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign din_s     = din_sync_q[SYNC_STAGES-1];
  // Armed only once a genuine (post-flush) high cs is seen, so cs held low across reset can't start a frame.
  assign cs_fall   = armed_q & cs_prev_q & ~cs_s;
  assign cs_rise   = ~cs_prev_q & cs_s;
  assign sclk_fall = sclk_prev_q & ~sclk_s;
  assign ctl_new   = {ctl_sr_q[14:0], din_s};
  assign ctl_unused = ^{ctl_sr_q[15], ctl_new[14:13], ctl_new[9:0]};

  always_comb begin
    cs_sync_d     = {cs_sync_q[SYNC_STAGES-2:0], cs};
    sclk_sync_d   = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    din_sync_d    = {din_sync_q[SYNC_STAGES-2:0], d_in};
    cs_prev_d     = cs_s;
    sclk_prev_d   = sclk_s;
    flush_cnt_d   = (flush_cnt_q == FLUSH) ? flush_cnt_q : flush_cnt_q + 2'd1;
    armed_d       = armed_q | ((flush_cnt_q == FLUSH) & cs_s);
    state_d       = state_q;
    out_sr_d      = out_sr_q;
    ctl_sr_d      = ctl_sr_q;
    bit_cnt_d     = bit_cnt_q;
    d_out_d       = d_out_q;
    d_out_oe_d    = d_out_oe_q;
    cur_chan_d    = cur_chan_q;
    cfg_write_d   = 1'b0;
    frame_abort_d = 1'b0;
`ifdef AD79X8_SEQUENCER_EN
    seq_d         = seq_q;
`endif
    case (state_q)
      IDLE: begin
        d_out_d    = 1'b0;
        d_out_oe_d = 1'b0;
        if (cs_fall) begin
          state_d    = SHIFT;
          out_sr_d   = {1'b0, cur_chan_q, chan_res[cur_chan_q]};
          d_out_d    = 1'b0;
          d_out_oe_d = 1'b1;
          ctl_sr_d   = '0;
          bit_cnt_d  = '0;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d       = IDLE;
          d_out_d       = 1'b0;
          d_out_oe_d    = 1'b0;
          ctl_sr_d      = '0;
          frame_abort_d = 1'b1;
        end else if (sclk_fall) begin
          ctl_sr_d  = ctl_new;
          out_sr_d  = {out_sr_q[14:0], 1'b0};
          d_out_d   = out_sr_q[14];
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd15) begin
            state_d = HOLD;
            d_out_d = 1'b0;
            if (ctl_new[15]) begin
              cur_chan_d  = ctl_new[12:10];
              cfg_write_d = 1'b1;
`ifdef AD79X8_SEQUENCER_EN
              seq_d       = ctl_new[14];
`endif
            end
          end
        end
      end
      HOLD: begin
        d_out_d = 1'b0;
        if (cs_rise) begin
          state_d    = IDLE;
          d_out_oe_d = 1'b0;
`ifdef AD79X8_SEQUENCER_EN
          if (seq_q && !ctl_sr_q[15]) cur_chan_d = cur_chan_q + 3'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_sync_q     <= '1;
      sclk_sync_q   <= '0;
      din_sync_q    <= '0;
      cs_prev_q     <= 1'b1;
      sclk_prev_q   <= 1'b0;
      flush_cnt_q   <= '0;
      armed_q       <= 1'b0;
      state_q       <= IDLE;
      out_sr_q      <= '0;
      ctl_sr_q      <= '0;
      bit_cnt_q     <= '0;
      d_out_q       <= 1'b0;
      d_out_oe_q    <= 1'b0;
      cur_chan_q    <= '0;
      cfg_write_q   <= 1'b0;
      frame_abort_q <= 1'b0;
`ifdef AD79X8_SEQUENCER_EN
      seq_q         <= 1'b0;
`endif
    end else begin
      cs_sync_q     <= cs_sync_d;
      sclk_sync_q   <= sclk_sync_d;
      din_sync_q    <= din_sync_d;
      cs_prev_q     <= cs_prev_d;
      sclk_prev_q   <= sclk_prev_d;
      flush_cnt_q   <= flush_cnt_d;
      armed_q       <= armed_d;
      state_q       <= state_d;
      out_sr_q      <= out_sr_d;
      ctl_sr_q      <= ctl_sr_d;
      bit_cnt_q     <= bit_cnt_d;
      d_out_q       <= d_out_d;
      d_out_oe_q    <= d_out_oe_d;
      cur_chan_q    <= cur_chan_d;
      cfg_write_q   <= cfg_write_d;
      frame_abort_q <= frame_abort_d;
`ifdef AD79X8_SEQUENCER_EN
      seq_q         <= seq_d;
`endif
    end
  end

  assign d_out       = d_out_q;
  assign d_out_oe    = d_out_oe_q;
  assign cur_chan    = cur_chan_q;
  assign cfg_write   = cfg_write_q;
  assign frame_abort = frame_abort_q;
endmodule

// File: tb/tb_ad79x8_slave.sv
// Bench for ad79x8_slave: directed vector table, hand-written corner sequences, random frames vs. a frame-level model.
module tb_ad79x8_slave;
  localparam int DB = 12;

  logic            clk = 1'b0;
  logic            rst_n, cs, sclk, d_in;
  logic [8*DB-1:0] samples;
  logic            d_out, d_out_oe, cfg_write, frame_abort;
  logic [2:0]      cur_chan;

  int checks = 0;
  int failures = 0;
  int cfg_cnt = 0;
  int abort_cnt = 0;

  ad79x8_slave #(.SYNC_STAGES(2), .DATA_BITS(DB)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .sclk(sclk), .d_in(d_in), .samples(samples),
    .d_out(d_out), .d_out_oe(d_out_oe), .cur_chan(cur_chan),
    .cfg_write(cfg_write), .frame_abort(frame_abort)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cfg_write) cfg_cnt <= cfg_cnt + 1;
    if (frame_abort) abort_cnt <= abort_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cs = 1'b1; sclk = 1'b1; d_in = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(6);
  endtask

  // Master: CPOL=1, d_out sampled and d_in driven ahead of each sclk falling edge.
  task automatic shift_bits(input logic [15:0] w, input int n, output logic [15:0] rx, output int late_nz);
    rx = '0;
    late_nz = 0;
    for (int k = 0; k < n; k++) begin
      if (k < 16) begin
        rx[15-k] = d_out;
        d_in = w[15-k];
      end else begin
        if (d_out !== 1'b0) late_nz++;
        d_in = 1'($urandom_range(0, 1));
      end
      tick(6); sclk = 1'b0;
      tick(6); sclk = 1'b1;
    end
    tick(6);
  endtask

  task automatic run_frame(input logic [15:0] w, input int n, output logic [15:0] rx,
                           output int cfg_d, output int abort_d, output int late_nz,
                           output logic hold_dout, output logic oe_mid);
    int c0, a0;
    c0 = cfg_cnt; a0 = abort_cnt;
    cs = 1'b0;
    tick(8);
    oe_mid = d_out_oe;
    shift_bits(w, n, rx, late_nz);
    hold_dout = d_out;
    cs = 1'b1;
    tick(8);
    cfg_d = cfg_cnt - c0;
    abort_d = abort_cnt - a0;
    $display("frame din=%h edges=%0d rx=%h cfg=%0d abort=%0d cur_chan=%0d oe=%b",
             w, n, rx, cfg_d, abort_d, cur_chan, d_out_oe);
  endtask

  function automatic logic [15:0] model_word(input int ch);
    logic [11:0] r;
    r = 12'(samples[ch*DB +: DB]) << (12 - DB);
    return {1'b0, 3'(ch), r};
  endfunction

  typedef struct {
    logic [15:0] din;
    int          edges;
    logic [15:0] rx;
    int          cfg;
    int          abrt;
    logic [2:0]  chan;
  } vec_t;

  vec_t        vecs[8];
  logic [15:0] rx, mask, w, exp_rx;
  int          cfg_d, abort_d, late_nz, n, r, m_chan, ecfg, eab;
  logic        hold_dout, oe_mid, m_seq;
  bit          seq_en;

  initial begin
`ifdef AD79X8_SEQUENCER_EN
    seq_en = 1'b1;
`else
    seq_en = 1'b0;
`endif
    vecs[0] = '{16'h0000, 16, 16'h0A5C, 0, 0, 3'd0};
    vecs[1] = '{16'h8C00, 16, 16'h0A5C, 1, 0, 3'd3};
    vecs[2] = '{16'h0000, 16, 16'h3123, 0, 0, 3'd3};
    vecs[3] = '{16'h9C00,  7, 16'h3123, 0, 1, 3'd3};
    vecs[4] = '{16'h8400, 20, 16'h3123, 1, 0, 3'd1};
    vecs[5] = '{16'h0000, 16, 16'h1111, 0, 0, 3'd1};
    vecs[6] = '{16'hA000, 16, 16'h1111, 1, 0, 3'd0};
    vecs[7] = '{16'h3FFF, 16, 16'h0A5C, 0, 0, 3'd0};

    samples = {12'h777, 12'h666, 12'h555, 12'h444, 12'h123, 12'h222, 12'h111, 12'hA5C};

    // Reset state
    rst_n = 1'b0; cs = 1'b1; sclk = 1'b1; d_in = 1'b0;
    tick(2);
    check("rst_d_out", d_out, 0);
    check("rst_oe", d_out_oe, 0);
    check("rst_cur_chan", cur_chan, 0);
    check("rst_cfg_write", cfg_write, 0);
    check("rst_frame_abort", frame_abort, 0);
    rst_n = 1'b1;
    tick(6);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i].din, vecs[i].edges, rx, cfg_d, abort_d, late_nz, hold_dout, oe_mid);
      mask = (vecs[i].edges >= 16) ? 16'hFFFF : ~(16'hFFFF >> vecs[i].edges);
      check($sformatf("vec%0d_rx", i), rx & mask, vecs[i].rx & mask);
      check($sformatf("vec%0d_cfg", i), cfg_d, vecs[i].cfg);
      check($sformatf("vec%0d_abort", i), abort_d, vecs[i].abrt);
      check($sformatf("vec%0d_chan", i), cur_chan, vecs[i].chan);
      check($sformatf("vec%0d_oe_mid", i), oe_mid, 1);
      check($sformatf("vec%0d_oe_end", i), d_out_oe, 0);
      if (vecs[i].edges >= 16) check($sformatf("vec%0d_hold_dout", i), hold_dout, 0);
      if (vecs[i].edges > 16) check($sformatf("vec%0d_late_bits", i), late_nz, 0);
    end

    // Sequencer: write ADD=7 with SEQ, then two WRITE=0 frames
    do_reset();
    run_frame(16'hDC00, 16, rx, cfg_d, abort_d, late_nz, hold_dout, oe_mid);
    check("seq_write_cfg", cfg_d, 1);
    check("seq_write_chan", cur_chan, 7);
    run_frame(16'h0000, 16, rx, cfg_d, abort_d, late_nz, hold_dout, oe_mid);
    check("seq_f1_chan_field", rx[14:12], 7);
    check("seq_f1_data", rx[11:0], 12'h777);
    run_frame(16'h0000, 16, rx, cfg_d, abort_d, late_nz, hold_dout, oe_mid);
    check("seq_f2_chan_field", rx[14:12], seq_en ? 0 : 7);
    check("seq_after_chan", cur_chan, seq_en ? 1 : 7);

    // Reset mid-frame with cs held low: no restart until cs toggles
    do_reset();
    r = cfg_cnt; n = abort_cnt;
    cs = 1'b0;
    tick(8);
    shift_bits(16'h8C00, 5, rx, late_nz);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(4);
    check("midrst_oe", d_out_oe, 0);
    shift_bits(16'hFFFF, 16, rx, late_nz);
    check("midrst_no_data", rx, 0);
    check("midrst_oe_after", d_out_oe, 0);
    cs = 1'b1;
    tick(8);
    check("midrst_cfg", cfg_cnt - r, 0);
    check("midrst_abort", abort_cnt - n, 0);
    check("midrst_chan", cur_chan, 0);
    run_frame(16'h0000, 16, rx, cfg_d, abort_d, late_nz, hold_dout, oe_mid);
    check("midrst_next_rx", rx, 16'h0A5C);

    // Random frames against the frame-level model
    do_reset();
    m_chan = 0;
    m_seq = 1'b0;
    for (int t = 0; t < 40; t++) begin
      samples = {$urandom(), $urandom(), $urandom()};
      w = 16'($urandom());
      r = $urandom_range(0, 9);
      if (r < 6)      n = 16;
      else if (r < 8) n = $urandom_range(0, 15);
      else            n = $urandom_range(17, 20);
      exp_rx = model_word(m_chan);
      run_frame(w, n, rx, cfg_d, abort_d, late_nz, hold_dout, oe_mid);
      if (n >= 16) begin
        eab = 0;
        if (w[15]) begin
          ecfg = 1;
          m_chan = int'(w[12:10]);
          m_seq = seq_en ? w[14] : 1'b0;
        end else begin
          ecfg = 0;
          if (m_seq) m_chan = (m_chan + 1) % 8;
        end
      end else begin
        ecfg = 0;
        eab = 1;
      end
      mask = (n >= 16) ? 16'hFFFF : ~(16'hFFFF >> n);
      check($sformatf("rnd%0d_rx", t), rx & mask, exp_rx & mask);
      check($sformatf("rnd%0d_cfg", t), cfg_d, ecfg);
      check($sformatf("rnd%0d_abort", t), abort_d, eab);
      check($sformatf("rnd%0d_chan", t), cur_chan, m_chan);
      check($sformatf("rnd%0d_oe", t), d_out_oe, 0);
      if (n > 16) check($sformatf("rnd%0d_late_bits", t), late_nz, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
